// File: rtl/seq_ctrl_pkg.sv
// seq_ctrl_pkg: shared state encoding and default word width for the sequence-detector controller
package seq_ctrl_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: streams a parallel word MSB-first into a serial Mealy detector and tallies its matches
module seq_detect_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1),
    parameter int IW    = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             abort,
    input  logic             det_z,
    output logic             det_x,
    output logic             det_reset,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [IW-1:0]    first_idx,
    output logic [CW-1:0]    match_count
);
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IW-1:0]    cnt;
    logic             last;

    assign last = cnt == IW'(WIDTH - 1);

    // Controller FSM: every output is registered so the detector sees clean, full-cycle levels
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            cnt         <= '0;
            det_x       <= 1'b0;
            det_reset   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            first_idx   <= '0;
            match_count <= '0;
        end else if (abort && (state == ST_CLEAR || state == ST_SHIFT)) begin
            state       <= ST_IDLE;
            det_x       <= 1'b0;
            det_reset   <= 1'b1;
            busy        <= 1'b0;
            found       <= 1'b0;
            first_idx   <= '0;
            match_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_CLEAR;
                        shreg       <= data_in;
                        busy        <= 1'b1;
                        found       <= 1'b0;
                        first_idx   <= '0;
                        match_count <= '0;
                    end
                end
                ST_CLEAR: begin
                    state     <= ST_SHIFT;
                    cnt       <= '0;
                    det_reset <= 1'b0;
                    det_x     <= shreg[WIDTH-1];
                end
                ST_SHIFT: begin
                    if (det_z) begin
                        match_count <= match_count + 1'b1;
                        if (!found) begin
                            found     <= 1'b1;
                            first_idx <= cnt;
                        end
                    end
                    shreg <= shreg << 1;
                    cnt   <= cnt + 1'b1;
                    det_x <= last ? 1'b0 : shreg[WIDTH-2];
                    if (last) begin
                        state     <= ST_DONE;
                        det_reset <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed tests of the controller driving a behavioural echo / "11" detector
module tb_seq_detect_ctrl;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       abort = 1'b0;
    logic       det_z;
    logic       det_x;
    logic       det_reset;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] first_idx;
    logic [3:0] match_count;
    logic       mode = 1'b0;
    logic       prev = 1'b0;
    int         checks = 0;
    int         errors = 0;

    seq_detect_ctrl #(.WIDTH(8)) dut (
        .clock(clock), .reset(reset), .start(start), .data_in(data_in), .abort(abort),
        .det_z(det_z), .det_x(det_x), .det_reset(det_reset), .busy(busy), .done(done),
        .found(found), .first_idx(first_idx), .match_count(match_count)
    );

    always #5 clock = ~clock;

    // Detector model: mode 0 echoes x, mode 1 flags two consecutive ones
    always @(posedge clock) prev <= det_reset ? 1'b0 : det_x;
    assign det_z = mode ? (det_x & prev) : det_x;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_job(input logic [7:0] d);
        data_in = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic collect(output logic [7:0] bits);
        for (int i = 0; i < 8; i++) begin
            tick();
            bits[7-i] = det_x;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({det_reset, busy, done, found, det_x} !== 5'b10000 || match_count !== 4'd0) begin
            errors++;
            $display("FAIL reset: det_reset/busy/done/found/det_x=%b count=%0d, want 10000 count=0",
                     {det_reset, busy, done, found, det_x}, match_count);
        end
    endtask

    task automatic test_echo();
        logic [7:0] bits;
        mode = 1'b0;
        start_job(8'b1011_0010);
        checks++;
        if (busy !== 1'b1 || det_reset !== 1'b1 || det_x !== 1'b0) begin
            errors++;
            $display("FAIL echo_clear: busy=%b det_reset=%b det_x=%b, want 1 1 0", busy, det_reset, det_x);
        end
        collect(bits);
        checks++;
        if (bits !== 8'b1011_0010) begin
            errors++;
            $display("FAIL echo_bits: got %b want 10110010", bits);
        end
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || det_reset !== 1'b1) begin
            errors++;
            $display("FAIL echo_done: done=%b busy=%b det_reset=%b, want 1 0 1", done, busy, det_reset);
        end
        tick();
        checks++;
        if (done !== 1'b0 || match_count !== 4'd4 || found !== 1'b1 || first_idx !== 3'd0) begin
            errors++;
            $display("FAIL echo_result: done=%b count=%0d found=%b idx=%0d, want 0 4 1 0",
                     done, match_count, found, first_idx);
        end
    endtask

    task automatic test_pair_detector();
        logic [7:0] bits;
        int         pulses;
        mode = 1'b1;
        start_job(8'b0110_1110);
        collect(bits);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL pair_done_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (match_count !== 4'd3 || first_idx !== 3'd2 || found !== 1'b1) begin
            errors++;
            $display("FAIL pair_result: count=%0d idx=%0d found=%b, want 3 2 1", match_count, first_idx, found);
        end
        mode = 1'b0;
    endtask

    task automatic test_no_match();
        logic [7:0] bits;
        mode = 1'b0;
        start_job(8'h00);
        collect(bits);
        tick();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL nomatch_done: done=%b want 1", done);
        end
        tick();
        checks++;
        if (match_count !== 4'd0 || found !== 1'b0 || first_idx !== 3'd0 || bits !== 8'h00) begin
            errors++;
            $display("FAIL nomatch_result: count=%0d found=%b idx=%0d bits=%h, want 0 0 0 00",
                     match_count, found, first_idx, bits);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bits;
        mode = 1'b0;
        data_in = 8'hA5;
        start = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(i * 29 + 1);
            tick();
            bits[7-i] = det_x;
        end
        checks++;
        if (bits !== 8'hA5) begin
            errors++;
            $display("FAIL b2b_first_bits: got %h want a5", bits);
        end
        data_in = 8'h77;
        tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done: done=%b busy=%b, want 1 0", done, busy);
        end
        data_in = 8'h12;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b, want 0 0", busy, done);
        end
        data_in = 8'h3C;
        tick();
        checks++;
        if (busy !== 1'b1 || match_count !== 4'd0) begin
            errors++;
            $display("FAIL b2b_second_accept: busy=%b count=%0d, want 1 0", busy, match_count);
        end
        for (int i = 0; i < 8; i++) begin
            data_in = 8'(i * 53 + 7);
            tick();
            bits[7-i] = det_x;
        end
        start = 1'b0;
        checks++;
        if (bits !== 8'h3C) begin
            errors++;
            $display("FAIL b2b_second_bits: got %h want 3c", bits);
        end
        tick();
        tick();
        checks++;
        if (match_count !== 4'd4 || first_idx !== 3'd2 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second_result: count=%0d idx=%0d busy=%b, want 4 2 0", match_count, first_idx, busy);
        end
    endtask

    task automatic test_abort();
        logic [7:0] bits;
        int         pulses;
        mode = 1'b0;
        start_job(8'hFF);
        tick();
        tick();
        tick();
        tick();
        checks++;
        if (match_count !== 4'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: count=%0d busy=%b, want 3 1", match_count, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || det_reset !== 1'b1 || match_count !== 4'd0 || found !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b det_reset=%b count=%0d found=%b done=%b, want 0 1 0 0 0",
                     busy, det_reset, match_count, found, done);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done || busy) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles want 0", pulses);
        end
        start_job(8'b1001_0110);
        collect(bits);
        tick();
        tick();
        checks++;
        if (bits !== 8'b1001_0110 || match_count !== 4'd4 || first_idx !== 3'd0 || found !== 1'b1) begin
            errors++;
            $display("FAIL abort_rerun: bits=%b count=%0d idx=%0d found=%b, want 10010110 4 0 1",
                     bits, match_count, first_idx, found);
        end
    endtask

    task automatic test_reset_mid_job();
        int pulses;
        start_job(8'hF0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || det_reset !== 1'b1 || match_count !== 4'd0 || found !== 1'b0) begin
            errors++;
            $display("FAIL midreset: busy=%b det_reset=%b count=%0d found=%b, want 0 1 0 0",
                     busy, det_reset, match_count, found);
        end
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL midreset_done: got %0d pulses want 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_pair_detector();
        test_no_match();
        test_back_to_back();
        test_abort();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Controller that sequences a serial-input Mealy sequence detector.
- Accepts a parallel word and resets the detector for one cycle, then streams the word MSB-first into the detector's x input, one bit per clock.
- Samples the detector's Mealy output z on every streamed bit. Reports the match count and the bit index of the first match.
- Sits between a parallel producer (bench or CPU-side register) and the detector instance.

Parameters:
- WIDTH, 8, number of bits streamed per job (≥2).
- CW, $clog2(WIDTH+1), width of match_count.
- IW, $clog2(WIDTH), width of first_idx.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
- start  in  1  job request; accepted only when busy==0.
- data_in  in  WIDTH  word to stream; latched on the accept edge.
- abort  in  1  cancels a running job.
- det_z  in  1  detector Mealy output (combinational from det_x and detector state).
- det_x  out  1  serial bit to the detector.
- det_reset  out  1  active-high reset to the detector.
- busy  out  1  high in CLEAR and SHIFT.
- done  out  1  one-cycle pulse at job completion.
- found  out  1  at least one match seen in the last job.
- first_idx  out  IW  stream index (0 = MSB) of the first match.
- match_count  out  CW  number of cycles in SHIFT with det_z==1.

Behaviour:
- States: IDLE, CLEAR, SHIFT, DONE, encoded in 2 bits.
- Reset (reset==0 at edge):
  - state=IDLE.
  - det_x=0, det_reset=1, busy=0, done=0.
  - found=0, first_idx=0, match_count=0, internal shift register and bit counter =0.
- det_reset stays 1 in IDLE, so the detector is held in reset between jobs.
- IDLE:
  - If start==1, latch data_in into shreg, clear found/first_idx/match_count and set state→CLEAR.
  - Otherwise hold. Results from the previous job remain visible.
- CLEAR: exactly one cycle. det_reset=1, det_x=0, busy=1. Then →SHIFT with bit counter=0.
- SHIFT: WIDTH cycles, det_reset=0, busy=1.
  - det_x = shreg[WIDTH-1] (registered output, stable for the whole cycle).
  - At each edge, if det_z==1: match_count+1. If found==0, also set found=1 and first_idx=bit counter.
  - At each edge, shreg shifts left with zero fill and the counter increments.
  - When counter==WIDTH-1 at an edge →DONE.
- DONE: one cycle. done=1, busy=0, det_reset=1. Then →IDLE. start is ignored in DONE.
- Latency: accept edge at T. CLEAR occupies cycle T+1, SHIFT occupies T+2 … T+WIDTH+1, done=1 in cycle T+WIDTH+2. Next accept is possible at the edge ending cycle T+WIDTH+3.
- start while busy: ignored, no queueing.
- abort==1 in CLEAR or SHIFT:
  - →IDLE at that edge; done is not pulsed.
  - The det_z sample at that edge is discarded.
  - found/first_idx/match_count are cleared to 0.
- abort in IDLE/DONE: no effect. abort has priority over the det_z sample and over the SHIFT→DONE transition.
- match_count cannot overflow (max WIDTH fits CW bits).
- Reset mid-job: returns to the reset values above at that edge; no done pulse.

Decomposition:
- Shared package seq_ctrl_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_SHIFT=2'd2, ST_DONE=2'd3.
  - default WIDTH.
- No sub-module. The shift register, counter and FSM stay in one module; the detector is instantiated alongside it by the integrating level.

Test Plan:
- Reset: hold reset=0 for 2 edges, then release → det_reset=1, busy=0, done=0, match_count=0, found=0, det_x=0.
- Echo model (det_z = det_x): WIDTH=8, data_in=8'b1011_0010, start pulse at T → det_x sequence 1,0,1,1,0,0,1,0 over T+2..T+9; done=1 at T+10; match_count=4, found=1, first_idx=0.
- "11" Mealy model (z=1 when current and previous x are both 1, cleared by det_reset): data_in=8'b0110_1110 → match_count=3, first_idx=2, found=1; done exactly one cycle.
- No match: echo model, data_in=8'h00 → match_count=0, found=0, first_idx=0, done pulse at T+10.
- start held high for 20 cycles with data_in changing → only one job accepted per pass through IDLE; streamed bits equal the data_in latched on the accept edge; second job accepted at the edge ending cycle T+11.
- abort at T+5 (mid-SHIFT) → next cycle state IDLE, busy=0, det_reset=1, match_count=0, found=0, no done pulse. A subsequent start runs a full, correct job.
